// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store access sequencer.
//   - Opcodes that select a memory operation (ILOAD, STYPE).
//   - Load-type and store-type encodings, plus decode helpers from func3.
//   - Access-size helpers (0 = byte, 1 = halfword, 2 = word).
//   - FSM state enum used by the sequencer and exported on its debug port.
package lsu_pkg;

  localparam logic [6:0] OPCODE_ILOAD = 7'b0000011;
  localparam logic [6:0] OPCODE_STYPE = 7'b0100011;

  typedef enum logic [2:0] {
    LT_LB   = 3'b000,
    LT_LH   = 3'b001,
    LT_LW   = 3'b010,
    LT_LBU  = 3'b011,
    LT_LHU  = 3'b100,
    LT_NONE = 3'b111
  } load_type_e;

  typedef enum logic [1:0] {
    ST_SB   = 2'b00,
    ST_SH   = 2'b01,
    ST_SW   = 2'b10,
    ST_NONE = 2'b11
  } store_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  function automatic load_type_e decode_load(input logic [2:0] func3);
    case (func3)
      3'b000:  return LT_LB;
      3'b001:  return LT_LH;
      3'b010:  return LT_LW;
      3'b100:  return LT_LBU;
      3'b101:  return LT_LHU;
      default: return LT_NONE;
    endcase
  endfunction

  function automatic store_type_e decode_store(input logic [2:0] func3);
    case (func3)
      3'b000:  return ST_SB;
      3'b001:  return ST_SH;
      3'b010:  return ST_SW;
      default: return ST_NONE;
    endcase
  endfunction

  function automatic logic [1:0] load_size(input load_type_e t);
    case (t)
      LT_LH, LT_LHU: return 2'd1;
      LT_LW:         return 2'd2;
      default:       return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] store_size(input store_type_e t);
    case (t)
      ST_SH:   return 2'd1;
      ST_SW:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // An access is misaligned when its bytes straddle a word boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'd1) && (off == 2'd3)) || ((size == 2'd2) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_access_sequencer_if.sv
// lsu_access_sequencer_if: word-addressed req/ack data bus.
//   master (sequencer): drives bus_req, bus_we, bus_addr, bus_wdata, bus_be;
//                       samples bus_ack, bus_rdata.
//   slave  (memory):    the mirror image.
// bus_rdata is valid in the same cycle as bus_ack.
interface lsu_access_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the sequencer.
//   size, off   : access size code and byte offset within the word
//   wdata       : right-aligned store data
//   rdata_lo/hi : first and second bus read words (hi = 0 when unsplit)
//   ld_type     : load type selecting the extension
//   mask        : 8-bit byte mask across two adjacent words
//   wdata_lanes : 64-bit lane-positioned store data across two words
//   load_data   : shifted and sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  input  load_type_e  ld_type,
  output logic [7:0]  mask,
  output logic [63:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  size_mask;
  logic [31:0] rd;

  always_comb begin
    size_mask = 8'h0F;
    case (size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      default: size_mask = 8'h0F;
    endcase
  end

  assign mask        = size_mask << off;
  assign wdata_lanes = {32'd0, wdata} << {off, 3'b000};
  // Only the low word of the shifted pair is ever consumed.
  assign rd          = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});

  always_comb begin
    load_data = 32'd0;
    case (ld_type)
      LT_LB:   load_data = {{24{rd[7]}}, rd[7:0]};
      LT_LH:   load_data = {{16{rd[15]}}, rd[15:0]};
      LT_LW:   load_data = rd;
      LT_LBU:  load_data = {24'd0, rd[7:0]};
      LT_LHU:  load_data = {16'd0, rd[15:0]};
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_access_sequencer.sv
// lsu_access_sequencer: MEM-stage load/store sequencer.
// Decodes opcode/func3, issues word-aligned req/ack bus transactions with
// byte enables, and returns sign/zero-extended load data.
//
// Configuration macro: LSU_MISALIGN_EN
//   defined   : misaligned halfword/word accesses are split over two bus
//               transactions (ACC0 then ACC1); misalign_fault is constant 0.
//   undefined : misaligned accesses go straight to RESP with misalign_fault=1,
//               rsp_rdata=0 and no bus activity.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_*           MEM-stage request (valid/ready, opcode, func3, addr, wdata)
//   stall           pipeline hold while an access is outstanding
//   rsp_valid       one-cycle completion pulse with rsp_rdata / misalign_fault
//   bus             data bus (master side of lsu_access_sequencer_if)
//   dbg_state       current FSM state
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready
// and the opcode/func3 decode to a memory op; req_ready is high only in IDLE
// outside reset. Non-memory requests are never taken and never stall. On the
// bus, bus_req and its addr/we/be/wdata stay stable until the edge on which
// bus_ack is sampled high; bus_rdata is captured on that same edge.
module lsu_access_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [6:0]           req_opcode,
  input  logic [2:0]           req_func3,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 stall,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 misalign_fault,
  lsu_access_sequencer_if.master bus,
  output lsu_state_e           dbg_state
);

  // Request decode
  load_type_e  in_ld;
  store_type_e in_st;
  logic        in_is_load;
  logic        in_is_store;
  logic        in_mem_op;
  logic [1:0]  in_size;
  logic        accept;

  assign in_ld       = decode_load(req_func3);
  assign in_st       = decode_store(req_func3);
  assign in_is_load  = (req_opcode == OPCODE_ILOAD) && (in_ld != LT_NONE);
  assign in_is_store = (req_opcode == OPCODE_STYPE) && (in_st != ST_NONE);
  assign in_mem_op   = in_is_load || in_is_store;
  assign in_size     = in_is_store ? store_size(in_st) : load_size(in_ld);

  // Latched access
  lsu_state_e        state_q, state_d;
  logic              is_store_q;
  load_type_e        ld_type_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_word_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rsp_rdata_q;
`ifdef LSU_MISALIGN_EN
  logic [31:0]       rdata0_q;
`else
  logic              fault_q;
`endif

  // Lane logic
  logic [7:0]  mask;
  logic [63:0] wdata_lanes;
  logic [31:0] load_data;
  logic [31:0] al_rdata_lo;
  logic [31:0] al_rdata_hi;
  logic        phase1;
  logic        final_ack;

  // ACC1 is unreachable without split support, so phase1 folds to 0 there.
  assign phase1 = (state_q == S_ACC1);

`ifdef LSU_MISALIGN_EN
  assign al_rdata_lo = phase1 ? rdata0_q : bus.bus_rdata;
  assign al_rdata_hi = phase1 ? bus.bus_rdata : 32'd0;
`else
  assign al_rdata_lo = bus.bus_rdata;
  assign al_rdata_hi = 32'd0;
`endif

  lsu_align u_align (
    .size        (size_q),
    .off         (off_q),
    .wdata       (wdata_q),
    .rdata_lo    (al_rdata_lo),
    .rdata_hi    (al_rdata_hi),
    .ld_type     (ld_type_q),
    .mask        (mask),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data)
  );

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready && in_mem_op;
  assign stall     = (state_q != S_IDLE) || accept;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;

`ifdef LSU_MISALIGN_EN
  assign misalign_fault = 1'b0;
`else
  assign misalign_fault = fault_q && (state_q == S_RESP);
`endif

  // Next state and bus outputs
  always_comb begin
    state_d       = state_q;
    final_ack     = 1'b0;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_be    = 4'd0;
    bus.bus_wdata = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef LSU_MISALIGN_EN
          state_d = S_ACC0;
`else
          state_d = is_misaligned(in_size, req_addr[1:0]) ? S_RESP : S_ACC0;
`endif
        end
      end
      S_ACC0, S_ACC1: begin
        bus.bus_req   = 1'b1;
        bus.bus_we    = is_store_q;
        bus.bus_addr  = phase1 ? (addr_word_q + ADDR_W'(4)) : addr_word_q;
        bus.bus_be    = phase1 ? mask[7:4] : mask[3:0];
        bus.bus_wdata = phase1 ? wdata_lanes[63:32] : wdata_lanes[31:0];
        if (bus.bus_ack) begin
`ifdef LSU_MISALIGN_EN
          // Any byte in the upper half of the mask means the access spills
          // into the next word.
          if ((state_q == S_ACC0) && (mask[7:4] != 4'd0)) begin
            state_d = S_ACC1;
          end else begin
            state_d   = S_RESP;
            final_ack = 1'b1;
          end
`else
          state_d   = S_RESP;
          final_ack = 1'b1;
`endif
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q  <= 1'b0;
      ld_type_q   <= LT_NONE;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      addr_word_q <= '0;
      wdata_q     <= 32'd0;
      rsp_rdata_q <= 32'd0;
`ifdef LSU_MISALIGN_EN
      rdata0_q    <= 32'd0;
`else
      fault_q     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        is_store_q  <= in_is_store;
        ld_type_q   <= in_is_store ? LT_NONE : in_ld;
        size_q      <= in_size;
        off_q       <= req_addr[1:0];
        addr_word_q <= {req_addr[ADDR_W-1:2], 2'b00};
        wdata_q     <= req_wdata;
`ifndef LSU_MISALIGN_EN
        fault_q     <= is_misaligned(in_size, req_addr[1:0]);
`endif
      end
      // Response data lives only for the RESP cycle; stores and faults read 0.
      rsp_rdata_q <= (final_ack && !is_store_q) ? load_data : 32'd0;
`ifdef LSU_MISALIGN_EN
      if ((state_q == S_ACC0) && bus.bus_ack) begin
        rdata0_q <= bus.bus_rdata;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lsu_access_sequencer.sv
module tb_lsu_access_sequencer;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign_fault;
  lsu_state_e  dbg_state;

  lsu_access_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_access_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_opcode     (req_opcode),
    .req_func3      (req_func3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .misalign_fault (misalign_fault),
    .bus            (bus),
    .dbg_state      (dbg_state)
  );

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];
  int          wait_cfg [2];
  int          txn_count;
  logic [31:0] txn_addr_q[$];
  logic [31:0] txn_wdata_q[$];
  logic [3:0]  txn_be_q[$];
  logic        txn_we_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory reference model (byte granular)
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] bus_word(input logic [31:0] wa);
    logic [31:0] w;
    if (bus_mem.exists(wa)) return bus_mem[wa];
    for (int i = 0; i < 4; i++) w[8*i +: 8] = init_byte(wa + 32'(i));
    return w;
  endfunction

  task automatic poke_word(input logic [31:0] wa, input logic [31:0] d);
    bus_mem[wa] = d;
    for (int i = 0; i < 4; i++) ref_mem[wa + 32'(i)] = d[8*i +: 8];
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int nb;
    v  = 32'd0;
    nb = nbytes(f3);
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_byte(addr + 32'(i));
    if (!f3[2]) begin
      if (nb == 1) v = {{24{v[7]}}, v[7:0]};
      else if (nb == 2) v = {{16{v[15]}}, v[15:0]};
    end
    return v;
  endfunction

  // bus slave: configurable wait states, stability checks, logged transactions
  initial begin : responder
    int          wl;
    logic [31:0] a, wd, w;
    logic [3:0]  be;
    logic        we;
    wl = -1;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      bus.bus_ack = 1'b0;
      if (bus.bus_req === 1'b1 && rst === 1'b0) begin
        if (wl < 0) begin
          a  = bus.bus_addr;
          wd = bus.bus_wdata;
          be = bus.bus_be;
          we = bus.bus_we;
          txn_addr_q.push_back(a);
          txn_wdata_q.push_back(wd);
          txn_be_q.push_back(be);
          txn_we_q.push_back(we);
          check_eq("bus_addr_word", {30'd0, a[1:0]}, 32'd0);
          wl = wait_cfg[(txn_count > 1) ? 1 : txn_count];
          txn_count++;
        end else begin
          check_eq("hold_addr", bus.bus_addr, a);
          check_eq("hold_be", {28'd0, bus.bus_be}, {28'd0, be});
          check_eq("hold_we", {31'd0, bus.bus_we}, {31'd0, we});
          check_eq("hold_wdata", bus.bus_wdata, wd);
          check_eq("stall_wait", {31'd0, stall}, 32'd1);
        end
        if (wl == 0) begin
          w = bus_word(a);
          bus.bus_rdata = w;
          if (we) begin
            for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
            bus_mem[a] = w;
          end
          bus.bus_ack = 1'b1;
          wl = -1;
        end else begin
          wl--;
        end
      end else begin
        wl = -1;
      end
    end
  end

  task automatic check_txn(input int idx, input logic [31:0] addr, input logic [3:0] be,
                           input logic we);
    check_eq("txn_present", {31'd0, (txn_addr_q.size() > idx)}, 32'd1);
    if (txn_addr_q.size() > idx) begin
      check_eq("txn_addr", txn_addr_q[idx], addr);
      check_eq("txn_be", {28'd0, txn_be_q[idx]}, {28'd0, be});
      check_eq("txn_we", {31'd0, txn_we_q[idx]}, {31'd0, we});
    end
  endtask

  // driver: one request, full response check against the model
  task automatic do_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int w0, input int w1);
    bit          is_ld, is_st, crosses, fault;
    int          nb, ntx, exp_lat, lat;
    logic [31:0] exp_d;
    is_ld   = (op == OP_LD) && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    is_st   = (op == OP_ST) && (f3 inside {3'b000, 3'b001, 3'b010});
    nb      = nbytes(f3);
    crosses = (int'(addr[1:0]) + nb) > 4;
`ifdef LSU_MISALIGN_EN
    fault = 1'b0;
    ntx   = crosses ? 2 : 1;
`else
    fault = crosses;
    ntx   = crosses ? 0 : 1;
`endif
    wait_cfg[0] = w0;
    wait_cfg[1] = w1;
    txn_count   = 0;
    txn_addr_q.delete();
    txn_wdata_q.delete();
    txn_be_q.delete();
    txn_we_q.delete();

    @(negedge clk);
    req_valid  = 1'b1;
    req_opcode = op;
    req_func3  = f3;
    req_addr   = addr;
    req_wdata  = wd;
    #1;
    check_eq("req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("stall_present", {31'd0, stall}, {31'd0, (is_ld || is_st)});

    if (!(is_ld || is_st)) begin
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check_eq("ign_rsp", {31'd0, rsp_valid}, 32'd0);
        check_eq("ign_bus_req", {31'd0, bus.bus_req}, 32'd0);
        check_eq("ign_stall", {31'd0, stall}, 32'd0);
      end
      check_eq("ign_txns", txn_count, 0);
      return;
    end

    exp_d = (is_ld && !fault) ? ref_load(f3, addr) : 32'd0;
    exp_q.push_back(exp_d);
    if (is_st && !fault)
      for (int i = 0; i < nb; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
    exp_lat = 1 + ((ntx >= 1) ? (w0 + 1) : 0) + ((ntx == 2) ? (w1 + 1) : 0);

    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_opcode = 7'($urandom);
    req_func3  = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      check_eq("stall_busy", {31'd0, stall}, 32'd1);
    end while (!rsp_valid && lat < 60);

    check_eq("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    if (rsp_valid) begin
      check_eq("latency", lat, exp_lat);
      check_eq("rsp_rdata", rsp_rdata, exp_q.pop_front());
      check_eq("misalign_fault", {31'd0, misalign_fault}, {31'd0, fault});
      check_eq("txn_count", txn_count, ntx);
    end else begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    check_eq("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    check_eq("stall_after", {31'd0, stall}, 32'd0);
    check_eq("state_idle", 32'(dbg_state), 32'(S_IDLE));
  endtask

  // main sequence
  initial begin : main
    bit found;
    logic [6:0] op;
    logic [31:0] addr;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_opcode = 7'd0;
    req_func3  = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    txn_count  = 0;
    wait_cfg[0] = 0;
    wait_cfg[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_fault", {31'd0, misalign_fault}, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // aligned LW
    poke_word(32'h100, 32'hDEADBEEF);
    do_access(OP_LD, 3'b010, 32'h100, 32'd0, 0, 0);
    check_txn(0, 32'h100, 4'b1111, 1'b0);

    // LB / LBU on the top byte
    poke_word(32'h100, 32'h80FFFFFF);
    do_access(OP_LD, 3'b000, 32'h103, 32'd0, 0, 0);
    do_access(OP_LD, 3'b100, 32'h103, 32'd0, 0, 0);

    // SH in the upper half
    do_access(OP_ST, 3'b001, 32'h102, 32'h1234ABCD, 0, 0);
    check_txn(0, 32'h100, 4'b1100, 1'b1);
    if (txn_wdata_q.size() > 0) check_eq("sh_wdata", txn_wdata_q[0], 32'hABCD0000);

    // misaligned LW
    poke_word(32'h100, 32'h33221100);
    poke_word(32'h104, 32'h77665544);
    do_access(OP_LD, 3'b010, 32'h101, 32'd0, 0, 0);
`ifdef LSU_MISALIGN_EN
    check_txn(0, 32'h100, 4'b1110, 1'b0);
    check_txn(1, 32'h104, 4'b0001, 1'b0);
`endif

    // wait states
    do_access(OP_LD, 3'b010, 32'h104, 32'd0, 3, 0);
    do_access(OP_ST, 3'b010, 32'h108, 32'hCAFEF00D, 2, 0);
    do_access(OP_LD, 3'b101, 32'h10A, 32'd0, 1, 0);

    // ignored requests
    do_access(OP_LD, 3'b011, 32'h100, 32'd0, 0, 0);
    do_access(OP_ST, 3'b100, 32'h100, 32'd0, 0, 0);
    do_access(7'b0110011, 3'b010, 32'h100, 32'd0, 0, 0);

    // split SW across the top of the address space
    do_access(OP_ST, 3'b010, 32'hFFFFFFFE, 32'h89ABCDEF, 1, 2);
`ifdef LSU_MISALIGN_EN
    check_txn(0, 32'hFFFFFFFC, 4'b1100, 1'b1);
    check_txn(1, 32'h00000000, 4'b0011, 1'b1);
    if (txn_wdata_q.size() > 1) begin
      check_eq("wrap_wdata0", txn_wdata_q[0], 32'hCDEF0000);
      check_eq("wrap_wdata1", txn_wdata_q[1], 32'h000089AB);
    end
`endif
    do_access(OP_LD, 3'b010, 32'hFFFFFFFE, 32'd0, 0, 0);

    // reset in the middle of an access
    poke_word(32'h200, 32'h0BADF00D);
    poke_word(32'h204, 32'h600DCAFE);
    txn_count = 0;
`ifdef LSU_MISALIGN_EN
    wait_cfg[0] = 0;
    wait_cfg[1] = 20;
    addr = 32'h201;
`else
    wait_cfg[0] = 20;
    wait_cfg[1] = 0;
    addr = 32'h200;
`endif
    @(negedge clk);
    req_valid  = 1'b1;
    req_opcode = OP_LD;
    req_func3  = 3'b010;
    req_addr   = addr;
    @(posedge clk);
    #1 req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
`ifdef LSU_MISALIGN_EN
      if (dbg_state == S_ACC1) found = 1'b1;
`else
      if (dbg_state == S_ACC0) found = 1'b1;
`endif
    end
    check_eq("abort_reach", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_bus_req", {31'd0, bus.bus_req}, 32'd0);
    check_eq("abort_rsp", {31'd0, rsp_valid}, 32'd0);
    check_eq("abort_state", 32'(dbg_state), 32'(S_IDLE));
    check_eq("abort_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_eq("abort_quiet_rsp", {31'd0, rsp_valid}, 32'd0);
      check_eq("abort_quiet_req", {31'd0, bus.bus_req}, 32'd0);
    end
    do_access(OP_LD, 3'b010, 32'h204, 32'd0, 0, 0);
    do_access(OP_LD, 3'b001, 32'h203, 32'd0, 1, 1);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 9);
      op = (r < 5) ? OP_LD : (r < 9) ? OP_ST : 7'b0010011;
      if ($urandom_range(0, 4) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else addr = 32'h300 + 32'($urandom_range(0, 31));
      do_access(op, 3'($urandom_range(0, 7)), addr, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
